// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: PC generator state encoding and fetch-address constants.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INST_ALIGN       = 2;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator feeding fetch; mirrors fetch's PC register so id_pc/id_valid
// line up with inst, and handles stall replay, redirects and misaligned-target faults.
module pc_gen
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fault_pc
);

  pc_state_e   state, state_nxt;
  logic [31:0] f_pc, f_pc_nxt;
  logic [31:0] d_pc, d_pc_nxt;
  logic        d_valid, d_valid_nxt;
  logic        fault_nxt;
  logic [31:0] fault_pc_nxt;
  logic        target_aligned;

  assign target_aligned = (redirect_target[INST_ALIGN-1:0] == '0);

  always_comb begin
    pc           = f_pc;
    state_nxt    = state;
    f_pc_nxt     = f_pc;
    d_pc_nxt     = d_pc;
    d_valid_nxt  = d_valid;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;
    unique case (state)
      RESET: begin
        pc          = f_pc;
        d_pc_nxt    = RESET_PC;
        f_pc_nxt    = RESET_PC + 32'd4;
        d_valid_nxt = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        if (redirect_valid && target_aligned) begin
          pc          = redirect_target;
          d_pc_nxt    = redirect_target;
          f_pc_nxt    = redirect_target + 32'd4;
          d_valid_nxt = 1'b1;
        end else if (redirect_valid) begin
          // Re-present the current address so fetch does not touch the bad target.
          pc           = d_pc;
          fault_nxt    = 1'b1;
          fault_pc_nxt = redirect_target;
          d_valid_nxt  = 1'b0;
          state_nxt    = HALT;
        end else if (stall) begin
          pc = d_pc;
        end else begin
          pc       = f_pc;
          d_pc_nxt = f_pc;
          f_pc_nxt = f_pc + 32'd4;
        end
      end
      HALT: begin
        pc = d_pc;
      end
      default: begin
        state_nxt = RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RESET;
      f_pc     <= RESET_PC;
      d_pc     <= '0;
      d_valid  <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_nxt;
      f_pc     <= f_pc_nxt;
      d_pc     <= d_pc_nxt;
      d_valid  <= d_valid_nxt;
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  assign id_pc    = d_pc;
  assign id_valid = d_valid;

endmodule
